// File: rtl/count_frame_packer.sv
// count_frame_packer
//   Snapshots all channel counts on batch_done and serialises them as one
//   framed byte stream to a UART byte sender over a start/done handshake:
//     SYNC_BYTE, channel 0..N_CH-1 (MSB byte first per channel) [, checksum]
//
// Optional feature macro: FRAME_CSUM_EN
//   defined   -> a trailing 8-bit sum (mod 256) of the data bytes is sent
//   undefined -> no checksum state or adder; the frame ends after the last data byte
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   batch_done  in   1-cycle snapshot request
//   counts      in   N_CH*COUNT_W packed counts, channel 0 in LSBs
//   tx_done     in   1-cycle pulse: current byte finished
//   tx_data     out  byte to transmit, stable from tx_start until tx_done
//   tx_start    out  1-cycle launch pulse
//   busy        out  high from snapshot until the cycle after the final tx_done
//   overrun     out  sticky: a batch_done arrived while busy and was dropped
module count_frame_packer #(
  parameter int unsigned N_CH      = 9,
  parameter int unsigned COUNT_W   = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    batch_done,
  input  logic [N_CH*COUNT_W-1:0] counts,
  input  logic                    tx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned BPC      = COUNT_W / 8;
  localparam int unsigned N_BYTES  = N_CH * BPC;
  localparam int unsigned IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SYNC,
    WAIT_SYNC,
    LOAD_DATA,
    WAIT_DATA
`ifdef FRAME_CSUM_EN
    ,
    LOAD_CSUM,
    WAIT_CSUM
`endif
  } state_t;

  state_t                  state, state_n;
  logic [N_CH*COUNT_W-1:0] snapshot;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [7:0]              data_n;
  logic                    load_snap;
  logic [7:0]              frame_bytes [N_BYTES];
`ifdef FRAME_CSUM_EN
  logic [7:0]              csum, csum_n;
`endif

  // Byte-order view of the snapshot: frame data index -> byte, so the FSM
  // only ever needs a plain array lookup.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar b = 0; b < BPC; b++) begin : g_byte
      assign frame_bytes[c*BPC + b] = snapshot[c*COUNT_W + COUNT_W - 8*(b+1) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      overrun  <= 1'b0;
      snapshot <= '0;
      idx      <= '0;
`ifdef FRAME_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      state   <= state_n;
      tx_data <= data_n;
      idx     <= idx_n;
      if (load_snap) snapshot <= counts;
      if (batch_done && (state != IDLE)) overrun <= 1'b1;
`ifdef FRAME_CSUM_EN
      csum    <= csum_n;
`endif
    end
  end

  // tx_data is loaded on the edge that enters a LOAD state, so it is already
  // valid during the cycle tx_start is high and simply held through WAIT.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    data_n    = tx_data;
    load_snap = 1'b0;
`ifdef FRAME_CSUM_EN
    csum_n    = csum;
`endif
    case (state)
      IDLE: begin
        if (batch_done) begin
          state_n   = LOAD_SYNC;
          data_n    = SYNC_BYTE;
          idx_n     = '0;
          load_snap = 1'b1;
`ifdef FRAME_CSUM_EN
          csum_n    = '0;
`endif
        end
      end
      LOAD_SYNC: state_n = WAIT_SYNC;
      WAIT_SYNC: begin
        if (tx_done) begin
          state_n = LOAD_DATA;
          idx_n   = '0;
          data_n  = frame_bytes[0];
`ifdef FRAME_CSUM_EN
          csum_n  = csum + frame_bytes[0];
`endif
        end
      end
      LOAD_DATA: state_n = WAIT_DATA;
      WAIT_DATA: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
`ifdef FRAME_CSUM_EN
            state_n = LOAD_CSUM;
            data_n  = csum;
`else
            state_n = IDLE;
`endif
          end else begin
            state_n = LOAD_DATA;
            idx_n   = idx + IDX_W'(1);
            data_n  = frame_bytes[idx_n];
`ifdef FRAME_CSUM_EN
            csum_n  = csum + frame_bytes[idx_n];
`endif
          end
        end
      end
`ifdef FRAME_CSUM_EN
      LOAD_CSUM: state_n = WAIT_CSUM;
      WAIT_CSUM: if (tx_done) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == LOAD_SYNC) || (state == LOAD_DATA)
`ifdef FRAME_CSUM_EN
               || (state == LOAD_CSUM)
`endif
               ;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_count_frame_packer.sv
// Testbench for count_frame_packer (honours FRAME_CSUM_EN if defined).
module tb_count_frame_packer;

  localparam int unsigned N_CH    = 9;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned BPC     = COUNT_W / 8;
  localparam int unsigned N_BYTES = N_CH * BPC;
`ifdef FRAME_CSUM_EN
  localparam int unsigned FRAME_LEN = N_BYTES + 2;
`else
  localparam int unsigned FRAME_LEN = N_BYTES + 1;
`endif
  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [COUNT_W-1:0] cnt_arr_t [N_CH];
  typedef struct {
    cnt_arr_t   c;
    logic [7:0] exp_sum;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst, batch_done, tx_done, resp_done, inj_done;
  logic [N_CH*COUNT_W-1:0] counts;
  logic [7:0]              tx_data;
  logic                    tx_start, busy, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q  [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_tx;
  int         resp_cnt;

  always #5 clk = ~clk;

  assign tx_done = resp_done | inj_done;

  count_frame_packer #(.N_CH(N_CH), .COUNT_W(COUNT_W), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .batch_done(batch_done), .counts(counts),
    .tx_done(tx_done), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Byte sender: tx_done 10 cycles after each tx_start.
  initial begin
    resp_done = 1'b0;
    resp_cnt  = 0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (rst) resp_cnt = 0;
      else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) resp_done = 1'b1;
        end
        if (tx_start) resp_cnt = 10;
      end
    end
  end

  // Capture every launched byte; tx_data must hold between launches while busy.
  initial begin
    last_tx = '0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        rx_q.push_back(tx_data);
        last_tx = tx_data;
      end else if (busy) begin
        check("tx_data_hold", 32'(tx_data), 32'(last_tx));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pack(input cnt_arr_t c);
    counts = '0;
    for (int ch = N_CH - 1; ch >= 0; ch--)
      counts = {counts[N_CH*COUNT_W-COUNT_W-1:0], c[ch]};
  endtask

  task automatic pulse_batch();
    batch_done = 1'b1;
    tick();
    batch_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 800) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_size(input string name, input int sz);
    int n = 0;
    while (rx_q.size() < sz && n < 800) begin
      tick();
      n++;
    end
    check({name, "_size_timeout"}, 32'(rx_q.size() >= sz), 32'd1);
  endtask

  // Reference frame: SYNC, channel 0 first, MSB byte first, optional sum.
  task automatic expect_frame(input string name, input cnt_arr_t c,
                              input bit has_sum, input logic [7:0] exp_sum);
    logic [7:0] s, got_sum, bt;
    s = '0;
    exp_q.delete();
    exp_q.push_back(SYNC);
    for (int ch = 0; ch < N_CH; ch++)
      for (int b = 0; b < BPC; b++) begin
        bt = 8'((c[ch] >> (8 * (BPC - 1 - b))) & 16'hFF);
        exp_q.push_back(bt);
        s = s + bt;
      end
`ifdef FRAME_CSUM_EN
    exp_q.push_back(s);
`endif
    check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
      else n_tests++;
    if (has_sum && rx_q.size() > N_BYTES) begin
      got_sum = '0;
      for (int i = 1; i <= N_BYTES; i++) got_sum = got_sum + rx_q[i];
      check({name, "_datasum"}, 32'(got_sum), 32'(exp_sum));
    end
  endtask

  vec_t     tbl [4];
  cnt_arr_t c;
  int       sz;

  initial begin
    for (int k = 0; k < N_CH; k++) tbl[0].c[k] = 16'(k + 1);
    tbl[0].exp_sum = 8'h2D;
    for (int k = 0; k < N_CH; k++) tbl[1].c[k] = '0;
    tbl[1].c[0] = 16'h01FF;
    tbl[1].c[1] = 16'h0102;
    tbl[1].exp_sum = 8'h03;
    for (int k = 0; k < N_CH; k++) tbl[2].c[k] = '0;
    tbl[2].exp_sum = 8'h00;
    for (int k = 0; k < N_CH; k++) tbl[3].c[k] = '1;
    tbl[3].exp_sum = 8'hEE;

    rst = 1'b1; batch_done = 1'b0; inj_done = 1'b0; counts = '0;
    repeat (3) tick();
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_overrun",  32'(overrun),  0);
    check("rst_tx_data",  32'(tx_data),  0);
    rst = 1'b0;
    tick();

    // First-byte latency, then the table vectors back to back.
    rx_q.delete();
    pack(tbl[0].c);
    pulse_batch();
    check("lat_tx_start", 32'(tx_start), 1);
    check("lat_tx_data",  32'(tx_data),  32'(SYNC));
    check("lat_busy",     32'(busy),     1);
    wait_idle("vec0");
    expect_frame("vec0", tbl[0].c, 1'b1, tbl[0].exp_sum);
    for (int v = 1; v < 4; v++) begin
      rx_q.delete();
      pack(tbl[v].c);
      pulse_batch();
      wait_idle($sformatf("vec%0d", v));
      expect_frame($sformatf("vec%0d", v), tbl[v].c, 1'b1, tbl[v].exp_sum);
    end

    // Random frames, each requested the first cycle busy is low.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N_CH; k++) c[k] = COUNT_W'($urandom);
      rx_q.delete();
      pack(c);
      pulse_batch();
      wait_idle("rand");
      expect_frame($sformatf("rand%0d", r), c, 1'b0, 8'h00);
    end
    check("no_overrun_yet", 32'(overrun), 0);

    // Snapshot isolation: inputs change one cycle after the request.
    for (int k = 0; k < N_CH; k++) c[k] = COUNT_W'(16'h1234 + 16'(k) * 16'h0111);
    rx_q.delete();
    pack(c);
    pulse_batch();
    counts = '1;
    wait_idle("snap");
    expect_frame("snap", c, 1'b0, 8'h00);

    // Requests while busy are dropped, including on the final tx_done cycle.
    for (int k = 0; k < N_CH; k++) c[k] = COUNT_W'($urandom);
    rx_q.delete();
    pack(c);
    pulse_batch();
    wait_size("ovr_mid", 7);
    pulse_batch();
    check("ovr_set", 32'(overrun), 1);
    begin
      int n = 0;
      while (!(resp_done && rx_q.size() == FRAME_LEN) && n < 800) begin
        tick();
        n++;
      end
      check("ovr_final_timeout", 32'(n < 800), 1);
    end
    pulse_batch();
    check("ovr_busy_fall", 32'(busy), 0);
    repeat (30) tick();
    check("ovr_no_frame", 32'(busy), 0);
    check("ovr_sticky", 32'(overrun), 1);
    expect_frame("ovr", c, 1'b0, 8'h00);

    // Reset mid-frame, tx_done while idle, then a clean frame.
    rx_q.delete();
    pack(tbl[3].c);
    pulse_batch();
    wait_size("rst_mid", 8);
    rst = 1'b1;
    tick();
    check("abort_busy",     32'(busy),     0);
    check("abort_tx_start", 32'(tx_start), 0);
    check("abort_tx_data",  32'(tx_data),  0);
    check("abort_overrun",  32'(overrun),  0);
    rst = 1'b0;
    tick();
    sz = rx_q.size();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (15) tick();
    check("idle_done_busy", 32'(busy), 0);
    check("idle_done_nostart", 32'(rx_q.size()), 32'(sz));
    rx_q.delete();
    pack(tbl[1].c);
    pulse_batch();
    wait_idle("post_rst");
    expect_frame("post_rst", tbl[1].c, 1'b1, tbl[1].exp_sum);

    // tx_done during every LOAD cycle must be ignored.
    for (int k = 0; k < N_CH; k++) c[k] = COUNT_W'($urandom);
    rx_q.delete();
    pack(c);
    pulse_batch();
    begin
      int n = 0;
      while (busy && n < 800) begin
        inj_done = tx_start;
        tick();
        n++;
      end
      inj_done = 1'b0;
      check("load_done_timeout", 32'(busy), 0);
    end
    expect_frame("load_done", c, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
